seq_divider: RTL

- Multi-cycle radix-2 restoring integer divider for the CPU execute stage.
- Performs one trial subtraction per cycle; this is the inverse arithmetic direction of the CLA adder path.
- Produces quotient and remainder for RISC-V DIV/DIVU/REM/REMU.
- Uses valid/ready handshakes on both input and output so the EXU can stall on it.

---
 rtl/seq_divider_if.sv | 42 ++++
 rtl/seq_divider.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Handshake and data bundle between the execute stage and the sequential divider.
// The requester side (EXU) uses the master modport, the divider uses slave.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             div_valid_i;
    logic             div_ready_o;
    logic             div_signed_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;

    modport master (
        output div_valid_i,
        output div_signed_i,
        output dividend_i,
        output divisor_i,
        output flush_i,
        output out_ready_i,
        input  div_ready_o,
        input  out_valid_o,
        input  quotient_o,
        input  remainder_o
    );

    modport slave (
        input  div_valid_i,
        input  div_signed_i,
        input  dividend_i,
        input  divisor_i,
        input  flush_i,
        input  out_ready_i,
        output div_ready_o,
        output out_valid_o,
        output quotient_o,
        output remainder_o
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one trial subtraction per cycle, MSB first.
// Operands are latched as magnitudes; signs are reapplied on the final step.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  div_if
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Magnitude of v when en is set and v is negative, v unchanged otherwise.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic en);
        mag = (en && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Two's-complement negate when en is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        cond_neg = en ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    // Holds the unconsumed dividend bits at the top and the quotient bits
    // shifted in at the bottom; after WIDTH steps it is the raw quotient.
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             div_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic [WIDTH:0]   cand_s;
    logic [WIDTH:0]   diff_s;
    logic             qbit_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;
    logic             accept_s;
    logic             div_zero_s;
    logic             overflow_s;

    // One restoring step on the current partial remainder.
    always_comb begin
        cand_s     = {rem_r, dvd_r[WIDTH-1]};
        diff_s     = cand_s - {1'b0, dvs_r};
        qbit_s     = ~diff_s[WIDTH];
        quo_step_s = {dvd_r[WIDTH-2:0], qbit_s};
        if (qbit_s) begin
            rem_step_s = diff_s[WIDTH-1:0];
        end else begin
            rem_step_s = {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
        end
    end

    // Request acceptance and special-case detection on the incoming operands.
    always_comb begin
        accept_s   = div_if.div_valid_i & div_ready_r & ~div_if.flush_i;
        div_zero_s = (div_if.divisor_i == {WIDTH{1'b0}});
        overflow_s = div_if.div_signed_i
                   & (div_if.dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                   & (div_if.divisor_i == {WIDTH{1'b1}});
    end

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            div_ready_r <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
        end else if (div_if.flush_i) begin
            // Abandon any work; result registers keep stale, unused data.
            state_r     <= ST_IDLE;
            div_ready_r <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        dvd_r       <= mag(div_if.dividend_i, div_if.div_signed_i);
                        dvs_r       <= mag(div_if.divisor_i, div_if.div_signed_i);
                        rem_r       <= {WIDTH{1'b0}};
                        cnt_r       <= CNT_W'(WIDTH);
                        q_neg_r     <= div_if.div_signed_i
                                     & (div_if.dividend_i[WIDTH-1] ^ div_if.divisor_i[WIDTH-1]);
                        r_neg_r     <= div_if.div_signed_i & div_if.dividend_i[WIDTH-1];
                        div_ready_r <= 1'b0;
                        if (div_zero_s) begin
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= div_if.dividend_i;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else if (overflow_s) begin
                            quotient_r  <= div_if.dividend_i;
                            remainder_r <= {WIDTH{1'b0}};
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            state_r     <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_r <= rem_step_s;
                    dvd_r <= quo_step_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        quotient_r  <= cond_neg(quo_step_s, q_neg_r);
                        remainder_r <= cond_neg(rem_step_s, r_neg_r);
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (div_if.out_ready_i) begin
                        out_valid_r <= 1'b0;
                        div_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    div_ready_r <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign div_if.div_ready_o = div_ready_r;
    assign div_if.out_valid_o = out_valid_r;
    assign div_if.quotient_o  = quotient_r;
    assign div_if.remainder_o = remainder_r;
endmodule
